pll_seq_ctrl: RTL and testbench

Power-up and lock-supervision sequencer for the four-output clock PLL. It holds the PLL in reset for a programmed width, waits for a filtered lock, and then enables the four downstream clock domains one at a time with a fixed stagger. It also recovers from lock timeouts and loss of lock, with a bounded number of automatic retries. It runs in the 50 MHz reference domain next to the PLL instance and drives the PLL reset and the per-output clock-enable gates.

---
 rtl/pll_ctrl_pkg.sv | 22 ++
 rtl/pll_seq_ctrl_lock_sync.sv | 25 ++
 rtl/pll_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL power-up / lock-supervision sequencer.
// Holds the FSM state encoding, default parameter values and the clock-enable width.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        ENABLE    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_e;

    localparam int unsigned DEF_RST_CYCLES   = 10;
    localparam int unsigned DEF_LOCK_FILT    = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT = 5000;
    localparam int unsigned DEF_STAGGER      = 4;
    localparam int unsigned DEF_MAX_RETRY    = 3;

    localparam int CLK_EN_W = 4;

endpackage

// File: rtl/pll_seq_ctrl_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL lock indicator into the
// reference clock domain; both stages clear to 0 so lock is never assumed out of reset.
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL reset / lock-filter / staggered clock-enable sequencer with bounded auto-retry.
// Build option: define PLL_AUTOSTART_EN to leave IDLE automatically after reset release.
module pll_seq_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned LOCK_FILT    = DEF_LOCK_FILT,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned STAGGER      = DEF_STAGGER,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic [CLK_EN_W-1:0] clk_en,
    output logic                ready,
    output logic                fail,
    output logic [1:0]          retry_cnt
);

    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);

    pll_state_e          state_q, state_d;
    logic                pll_rst_q, pll_rst_d;
    logic [CLK_EN_W-1:0] clk_en_q, clk_en_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
    logic [1:0]          retry_q, retry_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [1:0]          step_q, step_d;

    logic                lock_s;
    logic [FILT_W-1:0]   filt_inc;
    logic [TMO_W-1:0]    tmo_inc;

    lock_sync u_lock_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    // Counters only ever run up to their terminal value before the state changes.
    assign filt_inc = filt_q + FILT_W'(1);
    assign tmo_inc  = tmo_q + TMO_W'(1);

    always_comb begin
        state_d   = state_q;
        pll_rst_d = pll_rst_q;
        clk_en_d  = clk_en_q;
        ready_d   = ready_q;
        fail_d    = fail_q;
        retry_d   = retry_q;
        rst_cnt_d = rst_cnt_q;
        filt_d    = filt_q;
        tmo_d     = tmo_q;
        stg_d     = stg_q;
        step_d    = step_q;

        case (state_q)
            IDLE: begin
                pll_rst_d = 1'b1;
                clk_en_d  = '0;
                ready_d   = 1'b0;
                fail_d    = 1'b0;
`ifdef PLL_AUTOSTART_EN
                state_d   = RESET;
                rst_cnt_d = '0;
`else
                if (start) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                end
`endif
            end

            RESET: begin
                if (start) begin
                    pll_rst_d = 1'b1;
                    clk_en_d  = '0;
                    ready_d   = 1'b0;
                    retry_d   = 2'd0;
                    rst_cnt_d = '0;
                end else if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    filt_d    = '0;
                    tmo_d     = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            WAIT_LOCK: begin
                if (start) begin
                    state_d   = RESET;
                    pll_rst_d = 1'b1;
                    clk_en_d  = '0;
                    ready_d   = 1'b0;
                    retry_d   = 2'd0;
                    rst_cnt_d = '0;
                end else if (lock_s && (filt_inc == FILT_W'(LOCK_FILT))) begin
                    // Lock completion takes priority over a coincident timeout.
                    state_d  = ENABLE;
                    clk_en_d = CLK_EN_W'(1);
                    stg_d    = '0;
                    step_d   = 2'd0;
                end else begin
                    filt_d = lock_s ? filt_inc : '0;
                    if (tmo_inc == TMO_W'(LOCK_TIMEOUT)) begin
                        if (retry_q < 2'(MAX_RETRY)) begin
                            state_d   = RESET;
                            pll_rst_d = 1'b1;
                            retry_d   = retry_q + 2'd1;
                            rst_cnt_d = '0;
                        end else begin
                            state_d   = FAIL;
                            pll_rst_d = 1'b1;
                            fail_d    = 1'b1;
                            clk_en_d  = '0;
                        end
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end

            ENABLE: begin
                if (start || !lock_s) begin
                    state_d   = RESET;
                    pll_rst_d = 1'b1;
                    clk_en_d  = '0;
                    ready_d   = 1'b0;
                    rst_cnt_d = '0;
                    if (start) begin
                        retry_d = 2'd0;
                    end
                end else if (stg_q == STG_W'(STAGGER - 1)) begin
                    stg_d = '0;
                    if (step_q == 2'(CLK_EN_W - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        retry_d = 2'd0;
                    end else begin
                        step_d   = step_q + 2'd1;
                        clk_en_d = {clk_en_q[CLK_EN_W-2:0], 1'b1};
                    end
                end else begin
                    stg_d = stg_q + STG_W'(1);
                end
            end

            RUN: begin
                if (start || !lock_s) begin
                    state_d   = RESET;
                    pll_rst_d = 1'b1;
                    clk_en_d  = '0;
                    ready_d   = 1'b0;
                    rst_cnt_d = '0;
                    if (start) begin
                        retry_d = 2'd0;
                    end
                end
            end

            FAIL: begin
                pll_rst_d = 1'b1;
                clk_en_d  = '0;
                ready_d   = 1'b0;
                fail_d    = 1'b1;
                if (start) begin
                    state_d   = RESET;
                    fail_d    = 1'b0;
                    retry_d   = 2'd0;
                    rst_cnt_d = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                pll_rst_d = 1'b1;
                clk_en_d  = '0;
                ready_d   = 1'b0;
                fail_d    = 1'b0;
                retry_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pll_rst_q <= 1'b1;
            clk_en_q  <= '0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            retry_q   <= 2'd0;
            rst_cnt_q <= '0;
            filt_q    <= '0;
            tmo_q     <= '0;
            stg_q     <= '0;
            step_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            pll_rst_q <= pll_rst_d;
            clk_en_q  <= clk_en_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
            retry_q   <= retry_d;
            rst_cnt_q <= rst_cnt_d;
            filt_q    <= filt_d;
            tmo_q     <= tmo_d;
            stg_q     <= stg_d;
            step_q    <= step_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign clk_en    = clk_en_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: every output change is matched against a queue of
// expected (value, cycle) events; honours PLL_AUTOSTART_EN when defined.
module tb_pll_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pll_locked;
    logic       pll_rst;
    logic [3:0] clk_en;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [8:0] ovec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    string      tag_q[$];
    logic [8:0] vec_q[$];
    int         cyc_q[$];

    pll_seq_ctrl #(
        .RST_CYCLES   (10),
        .LOCK_FILT    (8),
        .LOCK_TIMEOUT (200),
        .STAGGER      (4),
        .MAX_RETRY    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .clk_en     (clk_en),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    assign ovec = {pll_rst, clk_en, ready, fail, retry_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] mk(input bit pr, input logic [3:0] en, input bit rdy,
                                      input bit fl, input logic [1:0] rc);
        return {pr, en, rdy, fl, rc};
    endfunction

    task automatic expect_ev(input string tag, input logic [8:0] v, input int c);
        tag_q.push_back(tag);
        vec_q.push_back(v);
        cyc_q.push_back(c);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Bring-up tail: staggered enables from entry edge e, then ready.
    task automatic expect_bringup(input string tag, input int e);
        expect_ev({tag, "_en0001"}, mk(0, 4'b0001, 0, 0, 2'd0), e);
        expect_ev({tag, "_en0011"}, mk(0, 4'b0011, 0, 0, 2'd0), e + 4);
        expect_ev({tag, "_en0111"}, mk(0, 4'b0111, 0, 0, 2'd0), e + 8);
        expect_ev({tag, "_en1111"}, mk(0, 4'b1111, 0, 0, 2'd0), e + 12);
        expect_ev({tag, "_ready"},  mk(0, 4'b1111, 1, 0, 2'd0), e + 16);
    endtask

    // Output-change monitor: one line per observed transaction, popped against the scoreboard.
    initial begin : monitor
        logic [8:0] prev;
        logic [8:0] cur;
        logic [8:0] ev;
        string      t;
        int         ec;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = ovec;
            if (mon_en && (cur !== prev)) begin
                $display("cyc=%0d pll_rst=%b clk_en=%b ready=%b fail=%b retry_cnt=%0d",
                         cyc, cur[8], cur[7:4], cur[3], cur[2], cur[1:0]);
                if (tag_q.size() == 0) begin
                    t  = "unexpected_change";
                    ev = 'x;
                    ec = -1;
                end else begin
                    t  = tag_q.pop_front();
                    ev = vec_q.pop_front();
                    ec = cyc_q.pop_front();
                end
                checks++;
                assert ((cur === ev) && (cyc == ec)) else begin
                    errors++;
                    $error("FAIL %s: got out=%b at cyc %0d, expected out=%b at cyc %0d",
                           t, cur, cyc, ev, ec);
                end
            end
            prev = cur;
        end
    end

    int r, t0, f, e, l, s, g, p, r2;

    initial begin : stimulus
        rst_n      = 1'b0;
        start      = 1'b0;
        pll_locked = 1'b0;

        @(negedge clk);
        checks++;
        assert (ovec === mk(1, 4'b0000, 0, 0, 2'd0)) else begin
            errors++;
            $error("FAIL reset_state: got %b, expected %b", ovec, mk(1, 4'b0000, 0, 0, 2'd0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        @(negedge clk);
        mon_en = 1'b1;
`ifdef PLL_AUTOSTART_EN
        expect_ev("autostart_rst_fall", mk(0, 4'b0000, 0, 0, 2'd0), r + 11);
        at_cyc(r + 20);
`endif

        // Nominal bring-up.
        t0 = cyc + 2;
        at_cyc(t0);
        start = 1'b1;
`ifdef PLL_AUTOSTART_EN
        expect_ev("nom_rst_rise", mk(1, 4'b0000, 0, 0, 2'd0), t0 + 1);
`endif
        f = t0 + 11;
        expect_ev("nom_rst_fall", mk(0, 4'b0000, 0, 0, 2'd0), f);
        @(negedge clk);
        start = 1'b0;
        at_cyc(f + 50);
        pll_locked = 1'b1;
        e = f + 60;
        expect_bringup("nom", e);

        // One-cycle lock loss in RUN, then automatic re-acquisition.
        l = e + 26;
        at_cyc(l);
        pll_locked = 1'b0;
        expect_ev("loss_drop",     mk(1, 4'b0000, 0, 0, 2'd0), l + 3);
        expect_ev("loss_rst_fall", mk(0, 4'b0000, 0, 0, 2'd0), l + 13);
        expect_bringup("reacq", l + 21);
        @(negedge clk);
        pll_locked = 1'b1;

        // Start abort from RUN, then a lock glitch during filtering.
        s = l + 47;
        at_cyc(s);
        start      = 1'b1;
        pll_locked = 1'b0;
        expect_ev("abort_run",      mk(1, 4'b0000, 0, 0, 2'd0), s + 1);
        expect_ev("glitch_rst_fall", mk(0, 4'b0000, 0, 0, 2'd0), s + 11);
        @(negedge clk);
        start = 1'b0;
        g = s + 16;
        at_cyc(g);
        pll_locked = 1'b1;
        expect_bringup("glitch", g + 18);
        at_cyc(g + 7);
        pll_locked = 1'b0;
        at_cyc(g + 8);
        pll_locked = 1'b1;

        // Timeouts with lock held low: four reset pulses then FAIL.
        s = g + 44;
        at_cyc(s);
        start      = 1'b1;
        pll_locked = 1'b0;
        expect_ev("tmo_abort", mk(1, 4'b0000, 0, 0, 2'd0), s + 1);
        for (int k = 0; k < 4; k++) begin
            expect_ev($sformatf("tmo_fall%0d", k), mk(0, 4'b0000, 0, 0, 2'(k)), s + 11 + 210 * k);
            if (k < 3)
                expect_ev($sformatf("tmo_retry%0d", k + 1), mk(1, 4'b0000, 0, 0, 2'(k + 1)),
                          s + 211 + 210 * k);
        end
        expect_ev("tmo_fail", mk(1, 4'b0000, 0, 1, 2'd3), s + 841);
        @(negedge clk);
        start = 1'b0;

        // Start from FAIL clears fail/retry_cnt; lock then brings up to clk_en=0011.
        p = s + 860;
        at_cyc(p);
        start = 1'b1;
        expect_ev("fail_restart",  mk(1, 4'b0000, 0, 0, 2'd0), p + 1);
        expect_ev("fail_rst_fall", mk(0, 4'b0000, 0, 0, 2'd0), p + 11);
        expect_ev("mid_en0001",    mk(0, 4'b0001, 0, 0, 2'd0), p + 21);
        expect_ev("mid_en0011",    mk(0, 4'b0011, 0, 0, 2'd0), p + 25);
        @(negedge clk);
        start = 1'b0;
        at_cyc(p + 11);
        pll_locked = 1'b1;

        // Asynchronous reset between edges while clk_en=0011.
        at_cyc(p + 27);
        mon_en     = 1'b0;
        pll_locked = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (ovec === mk(1, 4'b0000, 0, 0, 2'd0)) else begin
            errors++;
            $error("FAIL async_reset: got %b, expected %b", ovec, mk(1, 4'b0000, 0, 0, 2'd0));
        end
        $display("async reset applied: pll_rst=%b clk_en=%b ready=%b fail=%b retry_cnt=%0d",
                 pll_rst, clk_en, ready, fail, retry_cnt);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r2 = cyc;
`ifdef PLL_AUTOSTART_EN
        expect_ev("post_rst_autostart_fall", mk(0, 4'b0000, 0, 0, 2'd0), r2 + 11);
`endif
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
`ifndef PLL_AUTOSTART_EN
        at_cyc(r2 + 20);
        checks++;
        assert (ovec === mk(1, 4'b0000, 0, 0, 2'd0)) else begin
            errors++;
            $error("FAIL idle_after_reset: got %b, expected %b", ovec, mk(1, 4'b0000, 0, 0, 2'd0));
        end
        start = 1'b1;
        expect_ev("idle_start_fall", mk(0, 4'b0000, 0, 0, 2'd0), r2 + 31);
        @(negedge clk);
        start = 1'b0;
`endif
        at_cyc(r2 + 40);

        checks++;
        assert (tag_q.size() == 0) else begin
            errors++;
            $error("FAIL missing_events: got %0d pending, expected 0 (next %s at cyc %0d)",
                   tag_q.size(), tag_q[0], cyc_q[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
